// File: rtl/vga_scan_controller_if.sv
// Buffer-read and VGA pin bundle between the scan controller (master)
// and the frame buffer / VGA port side (slave).
interface vga_scan_controller_if;
  logic [11:0] ram_pixel_in;
  logic [7:0]  row_read;
  logic [8:0]  col_read;
  logic [3:0]  vga_red;
  logic [3:0]  vga_green;
  logic [3:0]  vga_blue;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        video_on;
  logic        frame_tick;

  modport master (
    input  ram_pixel_in,
    output row_read, col_read,
    output vga_red, vga_green, vga_blue,
    output vga_hsync, vga_vsync, video_on, frame_tick
  );

  modport slave (
    output ram_pixel_in,
    input  row_read, col_read,
    input  vga_red, vga_green, vga_blue,
    input  vga_hsync, vga_vsync, video_on, frame_tick
  );
endinterface

// File: rtl/vga_scan_controller.sv
// Scans a 320x240 buffer and drives pixel-doubled 640x480@60 VGA with aligned syncs.
// Optional VGA_BORDER_EN: forces a 1-pixel white frame around the visible area.
module vga_scan_controller #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  vga_scan_controller_if.master vga
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned ROW_W   = 8;
  localparam int unsigned COL_W   = 9;
  localparam int unsigned PIX_W   = 12;
  localparam int unsigned CH_W    = 4;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PIX_W-1:0] WHITE      = {PIX_W{1'b1}};

  logic             pix_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic             visible_c;
  logic             hsync_c;
  logic             vsync_c;
  logic             border_c;
  logic             tick_c;

  logic             visible_d1;
  logic             hsync_d1;
  logic             vsync_d1;
  logic             border_d1;

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [PIX_W-1:0] rgb_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             video_on_q;
  logic             frame_tick_q;

  // Pixel-rate enable and raster counters; both counters wrap explicitly.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Position decode straight from the counters.
  assign visible_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_c   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vsync_c   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign tick_c    = pix_en && (h_cnt == H_LAST) && (v_cnt == V_ACT_LAST);

`ifdef VGA_BORDER_EN
  assign border_c = (h_cnt == '0) || (h_cnt == H_ACT_LAST) ||
                    (v_cnt == '0) || (v_cnt == V_ACT_LAST);
`else
  assign border_c = 1'b0;
`endif

  // Stage 1: buffer address plus first delay of the position flags.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      row_q      <= '0;
      col_q      <= '0;
      visible_d1 <= 1'b0;
      hsync_d1   <= 1'b1;
      vsync_d1   <= 1'b1;
      border_d1  <= 1'b0;
    end else if (pix_en) begin
      if (visible_c) begin
        row_q <= v_cnt[ROW_W:1];
        col_q <= h_cnt[COL_W:1];
      end
      visible_d1 <= visible_c;
      hsync_d1   <= hsync_c;
      vsync_d1   <= vsync_c;
      border_d1  <= border_c;
    end
  end

  // Stage 2: buffer data arrives combinationally for the address held in stage 1.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else if (pix_en) begin
      if (!visible_d1) begin
        rgb_q <= '0;
      end else if (border_d1) begin
        rgb_q <= WHITE;
      end else begin
        rgb_q <= vga.ram_pixel_in;
      end
      hsync_q    <= hsync_d1;
      vsync_q    <= vsync_d1;
      video_on_q <= visible_d1;
    end
  end

  // Start-of-vertical-blanking pulse, one Clock wide, keyed off the counters.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= tick_c;
    end
  end

  assign vga.row_read   = row_q;
  assign vga.col_read   = col_q;
  assign vga.vga_red    = rgb_q[PIX_W-1 -: CH_W];
  assign vga.vga_green  = rgb_q[PIX_W-CH_W-1 -: CH_W];
  assign vga.vga_blue   = rgb_q[CH_W-1:0];
  assign vga.vga_hsync  = hsync_q;
  assign vga.vga_vsync  = vsync_q;
  assign vga.video_on   = video_on_q;
  assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: full-width lines, shortened frame (13 lines) to bound run time.
module tb_vga_scan_controller;

  localparam int unsigned T_V_ACT   = 6;
  localparam int unsigned T_V_FP    = 2;
  localparam int unsigned T_V_SYNC  = 2;
  localparam int unsigned T_V_BP    = 3;
  localparam int unsigned H_TOT     = 800;
  localparam int unsigned V_TOT     = T_V_ACT + T_V_FP + T_V_SYNC + T_V_BP;
  localparam int unsigned FRAME_PIX = H_TOT * V_TOT;
  localparam int unsigned TICK_POS  = (T_V_ACT - 1) * H_TOT + (H_TOT - 1);

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  logic done   = 1'b0;
  int   mode   = 0;

  always #10 Clock = ~Clock;

  vga_scan_controller_if vif();

  assign vif.ram_pixel_in = (mode != 0) ? 12'hABC : {vif.row_read[3:0], vif.col_read[7:0]};

  vga_scan_controller #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(T_V_ACT), .V_FP(T_V_FP), .V_SYNC(T_V_SYNC), .V_BP(T_V_BP)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .vga   (vif.master)
  );

  // Clock edges seen since reset release; the model is a pure function of this.
  int unsigned edges = 0;
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) edges <= 0;
    else         edges <= edges + 1;
  end

  function automatic logic border_at(input int unsigned h, input int unsigned v);
`ifdef VGA_BORDER_EN
    return (h == 0) || (h == 639) || (v == 0) || (v == T_V_ACT - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Expected pins after e clock edges: one pixel step per two edges, outputs two steps behind.
  function automatic logic [32:0] model(input int unsigned e, input int m);
    int unsigned s, q, p, h, v;
    logic [7:0]  row;
    logic [8:0]  col;
    logic [11:0] rgb;
    logic        hs, vs, von, ft;
    s = e / 2;
    row = '0; col = '0; rgb = '0; hs = 1'b1; vs = 1'b1; von = 1'b0; ft = 1'b0;
    if (s >= 1) begin
      q = (s - 1) % FRAME_PIX;
      h = q % H_TOT;
      v = q / H_TOT;
      if (v < T_V_ACT) begin
        row = 8'(v / 2);
        col = (h < 640) ? 9'(h / 2) : 9'd319;
      end else begin
        row = 8'((T_V_ACT - 1) / 2);
        col = 9'd319;
      end
      ft = (e % 2 == 0) && (q == TICK_POS);
    end
    if (s >= 2) begin
      p = (s - 2) % FRAME_PIX;
      h = p % H_TOT;
      v = p / H_TOT;
      hs  = !(h >= 656 && h < 752);
      vs  = !(v >= T_V_ACT + T_V_FP && v < T_V_ACT + T_V_FP + T_V_SYNC);
      von = (h < 640) && (v < T_V_ACT);
      if (von) rgb = border_at(h, v) ? 12'hFFF : ((m != 0) ? 12'hABC : {4'(v / 2), 8'(h / 2)});
    end
    return {rgb, hs, vs, von, ft, row, col};
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [32:0] act_v, exp_v;
  int cyc, hs_run, vs_run, von_run, ft_run, last_hs_fall, last_tick, first_von;
  logic prev_hs, prev_vs, prev_von, prev_ft, hs_fall_seen;
  int n_hs_per = 0, n_hs_low = 0, n_von = 0, n_vs = 0, n_ft_w = 0, n_ft_per = 0, n_rel = 0;
  int px20 = -1, px30 = -1, px02 = -1, px00 = -1, pxlast = -1;
  int row_max = 0, col_max = 0;
  int unsigned sp, pp, ph, pv;

  always @(negedge Clock) begin
    act_v = {vif.vga_red, vif.vga_green, vif.vga_blue, vif.vga_hsync, vif.vga_vsync,
             vif.video_on, vif.frame_tick, vif.row_read, vif.col_read};
    exp_v = model(edges, mode);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL pins edges=%0d got=%h expected=%h (rgb,hs,vs,von,tick,row,col)",
               edges, act_v, exp_v);
    end

    if (!Resetn) begin
      cyc = 0; hs_run = 0; vs_run = 0; von_run = 0; ft_run = 0;
      last_hs_fall = -1; last_tick = -1; first_von = -1;
      prev_hs = 1'b1; prev_vs = 1'b1; prev_von = 1'b0; prev_ft = 1'b0; hs_fall_seen = 1'b0;
    end else begin
      cyc++;
      if (!vif.vga_hsync) hs_run++;
      if (prev_hs && !vif.vga_hsync) begin
        if (last_hs_fall >= 0) begin
          check("hsync_fall_period", cyc - last_hs_fall, 1600);
          n_hs_per++;
        end
        last_hs_fall = cyc;
        if (!hs_fall_seen) begin
          hs_fall_seen = 1'b1;
          check("first_video_to_hsync_fall", cyc - first_von, 1312);
          n_rel++;
        end
      end
      if (!prev_hs && vif.vga_hsync) begin
        check("hsync_low_width", hs_run, 192);
        hs_run = 0;
        n_hs_low++;
      end

      if (vif.video_on) von_run++;
      if (!prev_von && vif.video_on && first_von < 0) first_von = cyc;
      if (prev_von && !vif.video_on) begin
        check("video_on_width", von_run, 1280);
        von_run = 0;
        n_von++;
      end

      if (!vif.vga_vsync) vs_run++;
      if (!prev_vs && vif.vga_vsync) begin
        check("vsync_low_width", vs_run, 3200);
        vs_run = 0;
        n_vs++;
      end

      if (vif.frame_tick) ft_run++;
      if (!prev_ft && vif.frame_tick) begin
        if (last_tick >= 0) begin
          check("frame_tick_period", cyc - last_tick, 2 * FRAME_PIX);
          n_ft_per++;
        end
        last_tick = cyc;
      end
      if (prev_ft && !vif.frame_tick) begin
        check("frame_tick_width", ft_run, 1);
        ft_run = 0;
        n_ft_w++;
      end

      prev_hs = vif.vga_hsync; prev_vs = vif.vga_vsync;
      prev_von = vif.video_on; prev_ft = vif.frame_tick;

      if (int'(vif.row_read) > row_max) row_max = int'(vif.row_read);
      if (int'(vif.col_read) > col_max) col_max = int'(vif.col_read);

      // Screen position on the pins is known from elapsed edges alone.
      sp = edges / 2;
      if (sp >= 2) begin
        pp = (sp - 2) % FRAME_PIX;
        ph = pp % H_TOT;
        pv = pp / H_TOT;
        if (mode == 0 && ph == 2 && pv == 0 && px20 < 0) px20 = int'(act_v[32:21]);
        if (mode == 0 && ph == 3 && pv == 0 && px30 < 0) px30 = int'(act_v[32:21]);
        if (mode == 0 && ph == 0 && pv == 2 && px02 < 0) px02 = int'(act_v[32:21]);
        if (mode != 0 && ph == 0 && pv == 0 && px00 < 0) px00 = int'(act_v[32:21]);
        if (mode != 0 && ph == 639 && pv == T_V_ACT - 1 && pxlast < 0) pxlast = int'(act_v[32:21]);
      end
    end

    if (done) begin
`ifdef VGA_BORDER_EN
      check("pixel_2_0", px20, 'hFFF);
      check("pixel_3_0", px30, 'hFFF);
      check("pixel_0_2", px02, 'hFFF);
      check("pixel_0_0_const", px00, 'hFFF);
      check("pixel_last_const", pxlast, 'hFFF);
`else
      check("pixel_2_0", px20, 'h001);
      check("pixel_3_0", px30, 'h001);
      check("pixel_0_2", px02, 'h100);
      check("pixel_0_0_const", px00, 'hABC);
      check("pixel_last_const", pxlast, 'hABC);
`endif
      check("col_read_max", col_max, 319);
      check("row_read_max", row_max, (T_V_ACT - 1) / 2);
      check("hsync_period_checks_enough", longint'(n_hs_per >= 25), 1);
      check("hsync_low_checks_enough", longint'(n_hs_low >= 25), 1);
      check("video_on_checks_enough", longint'(n_von >= 12), 1);
      check("vsync_checks_enough", longint'(n_vs >= 2), 1);
      check("tick_width_checks_enough", longint'(n_ft_w >= 3), 1);
      check("tick_period_checks_enough", longint'(n_ft_per >= 1), 1);
      check("post_reset_checks", n_rel, 2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    mode   = 0;
    Resetn = 1'b0;
    repeat (6) @(negedge Clock);
    #2 Resetn = 1'b1;
    // One full frame plus a few lines, so the frame wrap is crossed before the mid-frame reset.
    repeat (26400) @(negedge Clock);
    #2 Resetn = 1'b0;
    mode = 1;
    repeat (5) @(negedge Clock);
    #2 Resetn = 1'b1;
    repeat (31200) @(negedge Clock);
    done = 1'b1;
  end

endmodule

// File: doc/vga_scan_controller.md
# vga_scan_controller

Display-side stage that scans the 320×240 frame held in `vga_buffer_ram` and drives a 640×480 @ 60 Hz VGA port. It generates the buffer read address (`row_read`, `col_read`), samples the 12-bit pixel returned by the buffer, and emits pixel-doubled RGB with aligned sync and blanking. It also issues a once-per-frame tick so upstream mask offsets can be updated outside the visible region.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `Clock`  in  1  50 MHz system clock, rising edge
- `Resetn`  in  1  asynchronous, active-low reset
- `ram_pixel_in`  in  12  pixel from buffer; [11:8] R, [7:4] G, [3:0] B
- `row_read`  out  8  buffer read row, 0..239
- `col_read`  out  9  buffer read column, 0..319
- `vga_red`, `vga_green`, `vga_blue`  out  4 each  colour outputs
- `vga_hsync`, `vga_vsync`  out  1  active-low syncs
- `video_on`  out  1  high while output pixel is in the visible area
- `frame_tick`  out  1  one-`Clock` pulse at the start of vertical blanking

## Operation
- `pix_en` toggles every `Clock` edge and is 0 out of reset. All counters and pipeline registers advance only on edges where `pix_en`=1, giving a 25 MHz pixel rate.
- `h_cnt` runs 0..799 and wraps to 0. `v_cnt` increments when `h_cnt` wraps, runs 0..524, and wraps to 0.
- Address stage (registered): `col_read` ← `h_cnt[9:1]` and `row_read` ← `v_cnt[8:1]` when `h_cnt`<640 and `v_cnt`<480. Otherwise the addresses hold their last value. Each buffer pixel therefore covers a 2×2 screen block.
- The buffer read path is combinational. The output stage registers `ram_pixel_in` into RGB when the delayed visible flag is 1. Otherwise RGB is forced to 0.
- Sync decode from counters:
  - hsync low for `h_cnt` 656..751
  - vsync low for `v_cnt` 490..491
  - visible when `h_cnt`<640 and `v_cnt`<480
- These three signals pass through a 2-stage delay so they align with RGB.
- `frame_tick` is a registered pulse, 1 for exactly one `Clock` cycle, on the edge after the pixel step where `h_cnt`=799 and `v_cnt`=479. It is referenced to the counters, not the delayed outputs.
- Counter widths: `h_cnt` 10 bits, `v_cnt` 10 bits. There is no arithmetic beyond increment and compare, and no overflow is possible because both counters wrap explicitly.

## Timing
- Reset values: `row_read`=0, `col_read`=0, RGB=0, `vga_hsync`=1, `vga_vsync`=1, `video_on`=0, `frame_tick`=0. Internal state: `h_cnt`=0, `v_cnt`=0, `pix_en`=0.
- Latency: the output pins for counter position (h,v) appear 2 pixel steps (4 `Clock` cycles) after the counters hold (h,v). Sync, `video_on` and RGB share this latency.
- Line period: 800 pixel steps (1600 `Clock` cycles). Frame period: 525 lines (840 000 `Clock` cycles).
- Reset asserted mid-frame clears everything immediately. On release, scanning restarts at (0,0), and the first visible pixel reaches the pins 4 cycles after the first `pix_en`=1 edge.
- Last line boundary: at `h_cnt`=799, `v_cnt`=524, both counters wrap to 0 on the same step.

## Configuration
- `VGA_BORDER_EN` defined: output pixels whose delayed position has h∈{0,639} or v∈{0,479} are forced to 12'hFFF, giving a 1-pixel white frame. Latency is unchanged.
- `VGA_BORDER_EN` undefined: those pixels show buffer data like any other visible pixel.

## Test plan
- Reset check: hold `Resetn`=0 for 5 cycles → `vga_hsync`=1, `vga_vsync`=1, RGB=0, `row_read`=0, `col_read`=0, `frame_tick`=0 throughout.
- Line timing: run 2 lines → `vga_hsync` low for exactly 192 `Clock` cycles per line; falling edges 1600 cycles apart; `video_on` high for 1280 cycles per line.
- Frame timing: run one frame → `vga_vsync` low for exactly 3200 cycles; `frame_tick` high exactly once per 840 000 cycles, one cycle wide.
- Addressing and doubling: drive `ram_pixel_in`={row_read[3:0],col_read[7:0]} → screen pixels (2,0) and (3,0) both show 12'h001; (0,2) shows 12'h100; `col_read` never exceeds 319 and `row_read` never exceeds 239.
- Blanking: hold `ram_pixel_in`=12'hABC → RGB=12'hABC while `video_on`=1 and 0 during every blanking cycle. With `VGA_BORDER_EN` defined, pixels (0,0) and (639,479) show 12'hFFF.
- Mid-frame reset: assert `Resetn` at line 200 → outputs return to reset values on the same cycle; after release, the first `vga_hsync` falling edge occurs 1316 cycles after the first `pix_en`=1 edge.
